// File: rtl/painter_pkg.sv
// painter_pkg: shared types and constants for frame_sequencer and its helpers.
//   rgb_t          3-bit RGB colour
//   state_t        sequencer FSM state encoding
//   StFrameStart   state entered from reset and after every swap
//   PixelsDefault  default pixels per frame (160x120)
// Optional feature macro: FRAME_SEQUENCER_CLEAR_EN adds the CLEAR state.
package painter_pkg;

   localparam int unsigned PixelsDefault = 19200;

   typedef logic [2:0] rgb_t;

`ifdef FRAME_SEQUENCER_CLEAR_EN
   typedef enum logic [1:0] {StClear, StPaint, StWaitVb, StSwap} state_t;
   localparam state_t StFrameStart = StClear;
`else
   typedef enum logic [1:0] {StPaint, StWaitVb, StSwap} state_t;
   localparam state_t StFrameStart = StPaint;
`endif

endpackage

// File: rtl/rise_detect.sv
// rise_detect: rising-edge detector for a level already synchronous to clk.
//   clk    system clock
//   reset  synchronous active-high reset, clears the history to 0
//   level  sampled level
//   rise   high while level=1 and the previous cycle's level was 0
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic levelPrev;

   always_ff @(posedge clk) begin
      if (reset) begin
         levelPrev <= 1'b0;
      end else begin
         levelPrev <= level;
      end
   end

   assign rise = level & ~levelPrev;

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: sequences one video frame into the frame-buffer back buffer:
// optional clear, painter window, wait for vblank rising edge, buffer swap.
//   clk, reset          system clock, synchronous active-high reset
//   vblank              vertical blank level (synchronous to clk)
//   bg_color            clear colour
//   paint_req/addr/data painter write request
//   paint_done          painter finished the frame (one-cycle pulse)
//   paint_gnt           painter owns the write port
//   fb_we/addr/data     back-buffer write port
//   fb_swap             one-cycle swap pulse
//   oob                 sticky flag: painter wrote outside the frame
//   frame_count         completed swaps, wraps at 256
// Optional feature macro: FRAME_SEQUENCER_CLEAR_EN enables the CLEAR state
// (otherwise bg_color is unused and frames start directly in PAINT).
// Every output is registered from the current state and inputs, so outputs
// trail the state register by one cycle.
module frame_sequencer
   import painter_pkg::*;
#(
   parameter int unsigned PIXELS = PixelsDefault,
   parameter int unsigned ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vblank,
   input  logic [2:0]        bg_color,
   input  logic              paint_req,
   input  logic [ADDR_W-1:0] paint_addr,
   input  logic [2:0]        paint_data,
   input  logic              paint_done,
   output logic              paint_gnt,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [2:0]        fb_data,
   output logic              fb_swap,
   output logic              oob,
   output logic [7:0]        frame_count
);

   // One extra bit so PIXELS == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] PixLimit = (ADDR_W+1)'(PIXELS);

   state_t            state;
   state_t            nextState;
   logic              vbRise;
   logic              inFrame;
   logic              paintHit;
   logic              paintOob;
   logic              weD;
   logic [ADDR_W-1:0] addrD;
   rgb_t              dataD;

   rise_detect uRiseDetect (
      .clk   (clk),
      .reset (reset),
      .level (vblank),
      .rise  (vbRise)
   );

   assign inFrame  = ({1'b0, paint_addr} < PixLimit);
   assign paintHit = (state == StPaint) && paint_req && inFrame;
   assign paintOob = (state == StPaint) && paint_req && !inFrame;

`ifdef FRAME_SEQUENCER_CLEAR_EN
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(PIXELS - 1);

   logic [ADDR_W-1:0] clearAddr;
   logic              clearLast;

   assign clearLast = (clearAddr == LastAddr);

   // Held at 0 outside CLEAR, so every clear pass starts from address 0.
   always_ff @(posedge clk) begin
      if (reset || (state != StClear)) begin
         clearAddr <= '0;
      end else begin
         clearAddr <= clearAddr + ADDR_W'(1);
      end
   end
`else
   logic unusedBgColor;
   assign unusedBgColor = ^bg_color;
`endif

   always_comb begin
      nextState = state;
      case (state)
`ifdef FRAME_SEQUENCER_CLEAR_EN
         StClear:  if (clearLast) nextState = StPaint;
`endif
         StPaint:  if (paint_done) nextState = StWaitVb;
         StWaitVb: if (vbRise) nextState = StSwap;
         StSwap:   nextState = StFrameStart;
         default:  nextState = StFrameStart;
      endcase
   end

   // Address/data hold their last value when no write is issued.
   always_comb begin
      weD   = 1'b0;
      addrD = fb_addr;
      dataD = fb_data;
`ifdef FRAME_SEQUENCER_CLEAR_EN
      if (state == StClear) begin
         weD   = 1'b1;
         addrD = clearAddr;
         dataD = bg_color;
      end
`endif
      if (paintHit) begin
         weD   = 1'b1;
         addrD = paint_addr;
         dataD = paint_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StFrameStart;
         fb_we       <= 1'b0;
         fb_addr     <= '0;
         fb_data     <= '0;
         fb_swap     <= 1'b0;
         paint_gnt   <= 1'b0;
         oob         <= 1'b0;
         frame_count <= '0;
      end else begin
         state     <= nextState;
         fb_we     <= weD;
         fb_addr   <= addrD;
         fb_data   <= dataD;
         fb_swap   <= (state == StSwap);
         paint_gnt <= (state == StPaint);
         oob       <= oob | paintOob;
         if (state == StSwap) begin
            frame_count <= frame_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed bench for frame_sequencer with a phase-level
// reference model. Honours FRAME_SEQUENCER_CLEAR_EN like the design.
module tb_frame_sequencer;

   localparam int Pix = 19200;
`ifdef FRAME_SEQUENCER_CLEAR_EN
   localparam int NumFrames = 2;
`else
   localparam int NumFrames = 256;
`endif

   localparam int PhClear = 0;
   localparam int PhPaint = 1;
   localparam int PhWait  = 2;
   localparam int PhSwap  = 3;
`ifdef FRAME_SEQUENCER_CLEAR_EN
   localparam int PhStart = PhClear;
`else
   localparam int PhStart = PhPaint;
`endif

   logic        clk;
   logic        reset;
   logic        vblank;
   logic [2:0]  bg_color;
   logic        paint_req;
   logic [14:0] paint_addr;
   logic [2:0]  paint_data;
   logic        paint_done;
   logic        paint_gnt;
   logic        fb_we;
   logic [14:0] fb_addr;
   logic [2:0]  fb_data;
   logic        fb_swap;
   logic        oob;
   logic [7:0]  frame_count;

   int checks;
   int errors;

   frame_sequencer #(
      .PIXELS (Pix),
      .ADDR_W (15)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .vblank      (vblank),
      .bg_color    (bg_color),
      .paint_req   (paint_req),
      .paint_addr  (paint_addr),
      .paint_data  (paint_data),
      .paint_done  (paint_done),
      .paint_gnt   (paint_gnt),
      .fb_we       (fb_we),
      .fb_addr     (fb_addr),
      .fb_data     (fb_data),
      .fb_swap     (fb_swap),
      .oob         (oob),
      .frame_count (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: outputs after each edge follow from the phase the
   // sequencer was in before that edge and the inputs sampled at it.
   int          mPhase;
   int          mClearIdx;
   logic        mVbPrev;
   logic        eWe;
   logic [14:0] eAddr;
   logic [2:0]  eData;
   logic        eSwap;
   logic        eGnt;
   logic        eOob;
   logic [7:0]  eCount;

   always @(posedge clk) begin
      if (reset) begin
         mPhase    <= PhStart;
         mClearIdx <= 0;
         mVbPrev   <= 1'b0;
         eWe       <= 1'b0;
         eAddr     <= '0;
         eData     <= '0;
         eSwap     <= 1'b0;
         eGnt      <= 1'b0;
         eOob      <= 1'b0;
         eCount    <= '0;
      end else begin
         eWe     <= 1'b0;
         eSwap   <= 1'b0;
         eGnt    <= (mPhase == PhPaint);
         mVbPrev <= vblank;
         case (mPhase)
            PhClear: begin
               eWe   <= 1'b1;
               eAddr <= 15'(mClearIdx);
               eData <= bg_color;
               if (mClearIdx == Pix - 1) begin
                  mClearIdx <= 0;
                  mPhase    <= PhPaint;
               end else begin
                  mClearIdx <= mClearIdx + 1;
               end
            end
            PhPaint: begin
               if (paint_req) begin
                  if (int'(paint_addr) < Pix) begin
                     eWe   <= 1'b1;
                     eAddr <= paint_addr;
                     eData <= paint_data;
                  end else begin
                     eOob <= 1'b1;
                  end
               end
               if (paint_done) mPhase <= PhWait;
            end
            PhWait: if (vblank && !mVbPrev) mPhase <= PhSwap;
            PhSwap: begin
               eSwap  <= 1'b1;
               eCount <= eCount + 8'd1;
               mPhase <= PhStart;
            end
            default: mPhase <= PhStart;
         endcase
      end
   end

   task automatic compareModel();
      checks++;
      if ({fb_we, fb_swap, paint_gnt, oob, frame_count} !== {eWe, eSwap, eGnt, eOob, eCount}) begin
         errors++;
         $display("FAIL model_ctrl @%0t: got we=%b swap=%b gnt=%b oob=%b count=%0d, expected we=%b swap=%b gnt=%b oob=%b count=%0d",
                  $time, fb_we, fb_swap, paint_gnt, oob, frame_count,
                  eWe, eSwap, eGnt, eOob, eCount);
      end
      if (eWe === 1'b1) begin
         checks++;
         if ({fb_addr, fb_data} !== {eAddr, eData}) begin
            errors++;
            $display("FAIL model_write @%0t: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                     $time, fb_addr, fb_data, eAddr, eData);
         end
      end
   endtask

   // Advance one clock; outputs are checked on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      compareModel();
   endtask

   task automatic checkLit(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic waitGnt(input int budget);
      int n = 0;
      while (paint_gnt !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (paint_gnt !== 1'b1) begin
         errors++;
         $display("FAIL wait_gnt: paint_gnt not seen within %0d cycles", budget);
      end
   endtask

   task automatic waitSwap(input int budget);
      int n = 0;
      while (fb_swap !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (fb_swap !== 1'b1) begin
         errors++;
         $display("FAIL wait_swap: fb_swap not seen within %0d cycles", budget);
      end
   endtask

   task automatic doFrame(input int i);
      waitGnt(Pix + 8);
      paint_req  = 1'b1;
      paint_addr = 15'((i * 37) % Pix);
      paint_data = 3'(i % 8);
      paint_done = 1'b1;
      tick();
      paint_req  = 1'b0;
      paint_done = 1'b0;
      vblank     = 1'b0;
      tick();
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
      waitSwap(10);
      checkLit("frame_count_step", int'(frame_count), (i + 1) % 256);
      tick();
`ifndef FRAME_SEQUENCER_CLEAR_EN
      checkLit("gnt_after_frame_swap", int'(paint_gnt), 1);
`endif
   endtask

   int tblAddr[4] = '{0, Pix - 1, 7, 32767};
   int tblData[4] = '{1, 2, 4, 5};

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      vblank     = 1'b0;
      bg_color   = 3'b101;
      paint_req  = 1'b0;
      paint_addr = '0;
      paint_data = '0;
      paint_done = 1'b0;

      tick();
      tick();
      checkLit("reset_we", int'(fb_we), 0);
      checkLit("reset_gnt", int'(paint_gnt), 0);
      checkLit("reset_swap", int'(fb_swap), 0);
      checkLit("reset_oob", int'(oob), 0);
      checkLit("reset_count", int'(frame_count), 0);
      checkLit("reset_addr", int'(fb_addr), 0);

      reset = 1'b0;
      tick();
`ifdef FRAME_SEQUENCER_CLEAR_EN
      begin
         int weRun = 0;
         checkLit("clear_first_we", int'(fb_we), 1);
         checkLit("clear_first_addr", int'(fb_addr), 0);
         checkLit("clear_first_data", int'(fb_data), 5);
         if (fb_we === 1'b1) weRun++;
         for (int n = 1; n < Pix; n++) begin
            tick();
            if (fb_we === 1'b1) weRun++;
         end
         checkLit("clear_last_addr", int'(fb_addr), Pix - 1);
         checkLit("clear_we_cycles", weRun, Pix);
         checkLit("clear_gnt_low", int'(paint_gnt), 0);
         tick();
         checkLit("clear_gnt_rise", int'(paint_gnt), 1);
         checkLit("clear_done_we", int'(fb_we), 0);
      end
`else
      checkLit("gnt_after_reset", int'(paint_gnt), 1);
      checkLit("idle_we", int'(fb_we), 0);
`endif

      // Painter writes, in range and out of range.
      paint_req  = 1'b1;
      paint_addr = 15'd100;
      paint_data = 3'b011;
      tick();
      checkLit("paint_we", int'(fb_we), 1);
      checkLit("paint_addr", int'(fb_addr), 100);
      checkLit("paint_data", int'(fb_data), 3);
      paint_addr = 15'(Pix);
      paint_data = 3'b111;
      tick();
      checkLit("oob_drop_we", int'(fb_we), 0);
      checkLit("oob_set", int'(oob), 1);
      for (int i = 0; i < 4; i++) begin
         paint_addr = 15'(tblAddr[i]);
         paint_data = 3'(tblData[i]);
         tick();
      end
      paint_req = 1'b0;
      tick();
      checkLit("oob_sticky", int'(oob), 1);

      // Done with a same-cycle write while vblank is already high.
      vblank = 1'b1;
      tick();
      tick();
      paint_req  = 1'b1;
      paint_addr = 15'd5;
      paint_data = 3'b110;
      paint_done = 1'b1;
      tick();
      paint_done = 1'b0;
      paint_addr = 15'd9;
      paint_data = 3'b001;
      checkLit("done_write_we", int'(fb_we), 1);
      checkLit("done_write_addr", int'(fb_addr), 5);
      checkLit("done_write_data", int'(fb_data), 6);
      tick();
      checkLit("wait_gnt_low", int'(paint_gnt), 0);
      checkLit("wait_req_ignored", int'(fb_we), 0);
      paint_req  = 1'b0;
      paint_done = 1'b1;
      tick();
      paint_done = 1'b0;
      for (int n = 0; n < 4; n++) tick();
      checkLit("no_swap_vblank_held", int'(fb_swap), 0);
      checkLit("no_count_vblank_held", int'(frame_count), 0);
      vblank = 1'b0;
      tick();
      tick();
      vblank = 1'b1;
      tick();
      checkLit("swap_registered_late", int'(fb_swap), 0);
      tick();
      checkLit("swap_pulse", int'(fb_swap), 1);
      checkLit("swap_count", int'(frame_count), 1);
      vblank = 1'b0;
      tick();
      checkLit("swap_one_cycle", int'(fb_swap), 0);
`ifndef FRAME_SEQUENCER_CLEAR_EN
      checkLit("gnt_after_swap", int'(paint_gnt), 1);
`endif

      // Reset mid-frame abandons it.
`ifdef FRAME_SEQUENCER_CLEAR_EN
      begin
         int n = 0;
         while (!(fb_we === 1'b1 && fb_addr == 15'd5000) && n < Pix) begin
            tick();
            n++;
         end
         checkLit("clear_reached_5000", int'(fb_addr), 5000);
      end
`endif
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      checkLit("rst_mid_count", int'(frame_count), 0);
      checkLit("rst_mid_oob", int'(oob), 0);
`ifdef FRAME_SEQUENCER_CLEAR_EN
      checkLit("rst_mid_clear_we", int'(fb_we), 1);
      checkLit("rst_mid_clear_addr", int'(fb_addr), 0);
`else
      checkLit("rst_mid_gnt", int'(paint_gnt), 1);
`endif

      for (int i = 0; i < NumFrames; i++) doFrame(i);
`ifndef FRAME_SEQUENCER_CLEAR_EN
      checkLit("frame_count_wrap", int'(frame_count), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
